// File: rtl/approx_add1.sv
// Registered approximate ripple-carry adder. The low APPROX_LSBS cells output sum = ~carry_out.
// The remaining cells are exact full adders. An exact reference sum drives the err flag.
module approx_add1 #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned APPROX_LSBS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid,
  output logic             err
);

  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;
  logic [XW-1:0]    exact_c;
  logic             err_c;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  // Ripple chain: the carry is always exact; only the sum bit is approximated.
  always_comb begin
    carry_c    = '0;
    sum_c      = '0;
    carry_c[0] = c_in;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry_c[i+1] = (a[i] & b[i]) | (carry_c[i] & (a[i] ^ b[i]));
      if (i < APPROX_LSBS) begin
        sum_c[i] = ~carry_c[i+1];
      end else begin
        sum_c[i] = a[i] ^ b[i] ^ carry_c[i];
      end
    end
  end

  // Exact reference at WIDTH+1 bits for the mismatch flag.
  always_comb begin
    exact_c = XW'({1'b0, a}) + XW'({1'b0, b}) + XW'(c_in);
    err_c   = ({carry_c[WIDTH], sum_c} != exact_c);
  end

  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    err_d       = err_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum_c;
      c_out_d = carry_c[WIDTH];
      err_d   = err_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_approx_add1.sv
// Testbench for approx_add1: four configurations share one stimulus stream.
// Expected results are queued when operands are driven and compared when the outputs appear.
module tb_approx_add1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic       cin;

  logic [0:0] s1;  logic co1, ov1, e1;
  logic [3:0] s4e; logic co4e, ov4e, e4e;
  logic [3:0] s4a; logic co4a, ov4a, e4a;
  logic [7:0] s8;  logic co8, ov8, e8;

  int checks   = 0;
  int failures = 0;

  logic [39:0] sb_q[$];
  logic [39:0] held;
  logic [1:0]  tt [8];

  always #5 clk = ~clk;

  approx_add1 u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .a(a8[0:0]), .b(b8[0:0]),
    .c_in(cin), .sum(s1), .c_out(co1), .out_valid(ov1), .err(e1));
  approx_add1 #(.WIDTH(4), .APPROX_LSBS(0)) u4e (.clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8[3:0]), .b(b8[3:0]), .c_in(cin), .sum(s4e), .c_out(co4e), .out_valid(ov4e), .err(e4e));
  approx_add1 #(.WIDTH(4), .APPROX_LSBS(2)) u4a (.clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8[3:0]), .b(b8[3:0]), .c_in(cin), .sum(s4a), .c_out(co4a), .out_valid(ov4a), .err(e4a));
  approx_add1 #(.WIDTH(8), .APPROX_LSBS(5)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a8), .b(b8), .c_in(cin), .sum(s8), .c_out(co8), .out_valid(ov8), .err(e8));

  // Cell-level model: returns {err, c_out, sum[7:0]} for a w-bit adder with ap approximate cells.
  function automatic logic [9:0] model(input int w, input int ap, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci);
    logic [7:0] s;
    logic       c, co;
    logic [8:0] ex, ap_val, mask;
    s    = '0;
    c    = ci;
    mask = 9'((1 << w) - 1);
    for (int i = 0; i < w; i++) begin
      co   = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      s[i] = (i < ap) ? ~co : (a[i] ^ b[i] ^ c);
      c    = co;
    end
    ex     = (9'(a) & mask) + (9'(b) & mask) + 9'(ci);
    ap_val = 9'(s) | (9'(c) << w);
    return {ap_val != ex, c, s};
  endfunction

  function automatic logic [39:0] model_all(input logic [7:0] a, input logic [7:0] b,
                                            input logic ci);
    return {model(8, 5, a, b, ci), model(4, 2, a, b, ci), model(4, 0, a, b, ci),
            model(1, 1, a, b, ci)};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic exp_valid);
    logic [39:0] exp;
    logic [9:0]  obs[4];
    logic        ov[4];
    obs[0] = {e1, co1, 7'b0, s1};
    obs[1] = {e4e, co4e, 4'b0, s4e};
    obs[2] = {e4a, co4a, 4'b0, s4a};
    obs[3] = {e8, co8, s8};
    ov[0] = ov1; ov[1] = ov4e; ov[2] = ov4a; ov[3] = ov8;
    exp = held;
    if (exp_valid) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        failures++;
        $error("FAIL scoreboard_empty observed=0 expected>0");
      end
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      held = exp;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("result[%0d]", k), obs[k], exp[k*10 +: 10]);
      chk($sformatf("out_valid[%0d]", k), 10'(ov[k]), 10'(exp_valid));
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    in_valid = iv;
    a8       = a;
    b8       = b;
    cin      = ci;
    if (iv) sb_q.push_back(model_all(a, b, ci));
    @(posedge clk);
    #1;
    check_outputs(iv);
  endtask

  initial begin
    logic [7:0] ra, rb;
    // (sum,c_out) for (c_in,b,a) = 000..111
    tt[0] = 2'b10; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b01;
    held = '0;
    rst = 1'b1; in_valid = 1'b0; a8 = '0; b8 = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive single-cell truth table, upper bits randomised for the wider instances.
    for (int v = 0; v < 8; v++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ra[0] = v[0]; rb[0] = v[1];
      step(1'b1, ra, rb, v[2]);
      chk($sformatf("tt1[%0d]", v), {8'b0, s1, co1}, {8'b0, tt[v]});
      chk($sformatf("tt1_err[%0d]", v), 10'(e1), 10'((v == 0) || (v == 7)));
    end

    // Asynchronous reset between edges while c_out=1.
    step(1'b1, 8'h01, 8'h01, 1'b0);
    #2 rst = 1'b1;
    #1;
    held = '0;
    sb_q.delete();
    check_outputs(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    step(1'b0, 8'h5A, 8'hA5, 1'b1);
    step(1'b0, 8'hFF, 8'hFF, 1'b1);

    // Hold: outputs keep the last capture while in_valid=0.
    step(1'b1, 8'h01, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      chk("hold1", {7'b0, s1, co1, ov1}, 10'b0000000010);
    end

    // Directed 4-bit cases.
    step(1'b1, 8'h0F, 8'h01, 1'b0);
    chk("w4a0_f_1", {5'b0, e4e, co4e, s4e}, {5'b0, 1'b0, 1'b1, 4'h0});
    step(1'b1, 8'h05, 8'h03, 1'b1);
    chk("w4a0_5_3_1", {5'b0, e4e, co4e, s4e}, {5'b0, 1'b0, 1'b0, 4'h9});
    step(1'b1, 8'h00, 8'h00, 1'b0);
    chk("w4a2_0_0", {5'b0, e4a, co4a, s4a}, {5'b0, 1'b1, 1'b0, 4'b0011});
    step(1'b1, 8'h03, 8'h00, 1'b0);
    chk("w4a2_3_0", {5'b0, e4a, co4a, s4a}, {5'b0, 1'b0, 1'b0, 4'h3});

    // Back-to-back random vectors.
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    step(1'b0, 8'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_add1.md
Name: approx_add1

Overview:
- Registered approximate ripple-carry adder built from approximate full-adder cells. The cell computes the carry exactly and sets sum to the inverse of the carry-out (approximate mirror style).
- Used in the approximate-arithmetic datapath experiments alongside the core ALU.
- Also computes the exact result in parallel and flags when the approximate result differs from it.
- Default configuration is a single-bit approximate full adder with one-cycle registered outputs.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).
- APPROX_LSBS, WIDTH, number of least-significant cells that use the approximate cell; the remaining upper cells are exact full adders (legal range 0..WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high (fixed).
- in_valid  input  1  when 1, operands are captured on this clock edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  registered approximate sum.
- c_out  output  1  registered carry out of the MSB cell.
- out_valid  output  1  high for one cycle when sum/c_out/err hold a new result.
- err  output  1  registered flag: 1 when {c_out,sum} differs from the exact value a+b+c_in.

Behaviour:
- Reset: while rst=1, all outputs are forced to 0 asynchronously (sum=0, c_out=0, out_valid=0, err=0). Outputs stay 0 until the first captured operation after rst falls.
- Cell i (i=0..WIDTH-1), carry chain: cin_0 = c_in; co_i = (a_i&b_i) | (cin_i&(a_i^b_i)); cin_{i+1} = co_i. The carry is always exact.
- Cell sum, approximate cell (i < APPROX_LSBS): s_i = ~co_i.
- Cell sum, exact cell (i >= APPROX_LSBS): s_i = a_i ^ b_i ^ cin_i.
- c_out = co_{WIDTH-1}.
- Single-cell truth table for an approximate cell, written as (c_in,b,a) -> (sum,c_out):
  - 000 -> 1,0
  - 001 -> 1,0
  - 010 -> 1,0
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,1
  - 110 -> 0,1
  - 111 -> 0,1
  - Only 000 and 111 differ from an exact full adder.
- Exact reference: {c_out_exact, sum_exact} = a + b + c_in, computed at WIDTH+1 bits. err = ({co,s} != exact).
- Latency: exactly 1 cycle. Operands present with in_valid=1 at edge N produce sum/c_out/err and out_valid=1 after edge N.
- in_valid=0 at an edge: sum, c_out and err hold their previous values; out_valid=0.
- Back-to-back: in_valid=1 on consecutive edges gives a new result every cycle, with no bubbles.
- Reset mid-operation: an in-flight result is discarded. After reset releases, out_valid stays 0 until the next captured input.
- APPROX_LSBS=0: the block is an exact registered adder and err is always 0.
- The carry chain is purely combinational ripple. There is no internal pipelining beyond the output register.

Test Plan:
- Exhaustive 1-bit (defaults): apply all 8 (c_in,b,a) combinations 000..111, one per cycle with in_valid=1. Each result must match the truth table one cycle later. err=1 only for 000 (sum=1, c_out=0) and 111 (sum=0, c_out=1).
- Reset: assert rst asynchronously between edges while outputs are nonzero (after input 011). All outputs must go to 0 immediately, and out_valid stays 0 after release until in_valid=1.
- Hold: capture a=1, b=1, c_in=0 (sum=0, c_out=1), then drive in_valid=0 with changing inputs. Outputs must stay 0/1 and out_valid must be 0.
- WIDTH=4, APPROX_LSBS=0: a=4'hF, b=4'h1, c_in=0 -> sum=4'h0, c_out=1, err=0. a=4'h5, b=4'h3, c_in=1 -> sum=4'h9, c_out=0, err=0.
- WIDTH=4, APPROX_LSBS=2: a=4'h0, b=4'h0, c_in=0 -> sum=4'b0011, c_out=0, err=1. a=4'h3, b=4'h0, c_in=0 -> sum=4'h3, c_out=0, err=0.
- Back-to-back random: 1000 random vectors with in_valid=1 every cycle. Every output must match a scoreboard model of the cell equations, and err must match the comparison against the exact sum.
